// File: rtl/board_shuffle_loader.sv
// Shuffled Banqi board loader: Fisher-Yates over the 32 pieces, then 32 face-down writes.
// Latency: start -> first strobe is 2 cycles plus the shuffle; no backpressure, writes are unconditional.
module board_shuffle_loader #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        no_shuffle,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [4:0]  board_out_addr,
    output logic [4:0]  board_out_piece,
    output logic        board_change_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_step;
    logic        ns_q;
    logic [4:0]  idx;
    logic [4:0]  addr_cnt;
    logic [4:0]  draw;
    logic        accept;
    logic [4:0]  perm [32];

    // Smallest all-ones value covering i, so rejection keeps the draw uniform over 0..i.
    function automatic logic [4:0] draw_mask(input logic [4:0] i);
        if (i >= 5'd16)     return 5'd31;
        else if (i >= 5'd8) return 5'd15;
        else if (i >= 5'd4) return 5'd7;
        else if (i >= 5'd2) return 5'd3;
        else                return 5'd1;
    endfunction

    // Canonical layout: {color, type}; color is 1 (black) for the lower half.
    function automatic logic [3:0] canon(input logic [4:0] k);
        logic [2:0] kind;
        case (k[3:0])
            4'd0, 4'd7:                         kind = 3'b100;
            4'd1, 4'd6:                         kind = 3'b011;
            4'd2, 4'd5:                         kind = 3'b101;
            4'd3, 4'd13:                        kind = 3'b110;
            4'd4:                               kind = 3'b111;
            4'd11, 4'd12:                       kind = 3'b010;
            default:                            kind = 3'b001;
        endcase
        return {~k[4], kind};
    endfunction

    assign lfsr_step = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
    assign draw      = lfsr[4:0] & draw_mask(idx);
    assign accept    = (state == SHUFFLE) && (draw <= idx);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !seed_load) state_nxt = INIT;
            INIT:    state_nxt = ns_q ? WRITE : SHUFFLE;
            SHUFFLE: if (accept && idx == 5'd1) state_nxt = WRITE;
            WRITE:   if (addr_cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            lfsr     <= LFSR_SEED;
            ns_q     <= 1'b0;
            idx      <= 5'd0;
            addr_cnt <= 5'd0;
        end else begin
            state <= state_nxt;
            // A zero seed would lock the LFSR, so it falls back to the reset seed.
            if (state == IDLE && seed_load)
                lfsr <= (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
            else
                lfsr <= lfsr_step;
            if (state == IDLE && start && !seed_load)
                ns_q <= no_shuffle;
            case (state)
                INIT: begin
                    idx      <= 5'd31;
                    addr_cnt <= 5'd0;
                end
                SHUFFLE: if (accept) idx <= idx - 5'd1;
                WRITE:   addr_cnt <= addr_cnt + 5'd1;
                default: ;
            endcase
        end
    end

    // The permutation table carries no reset; INIT rebuilds it before every use.
    always_ff @(posedge CLK) begin
        if (state == INIT) begin
            for (int k = 0; k < 32; k++)
                perm[k] <= 5'(k);
        end else if (accept) begin
            perm[idx]  <= perm[draw];
            perm[draw] <= perm[idx];
        end
    end

    always_comb begin
        board_change_en = 1'b0;
        board_out_addr  = 5'd0;
        board_out_piece = 5'd0;
        busy            = (state != IDLE);
        done            = (state == DONE);
        if (state == WRITE) begin
            board_change_en = 1'b1;
            board_out_addr  = addr_cnt;
            board_out_piece = {canon(perm[addr_cnt]), 1'b0};
        end
    end

endmodule
